// File: rtl/sequential_divider_pkg.sv
// sequential_divider_pkg: shared opcode and state encodings for the iterative divider
// Holds the DIV opcode value used by the ALU control and the 2-bit divider FSM states.
package sequential_divider_pkg;
  localparam logic [3:0] DIV_OPCODE = 4'hD;
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } divState_t;
endpackage

// File: rtl/sequential_divider.sv
// sequential_divider: iterative unsigned restoring divider with busy/done handshake
// Ports: Clock/Reset (sync, active-high); iStart with iDividend/iDivisor request a division;
// oBusy high while iterating, oDone one-cycle result pulse, oQuotient/oRemainder/oDivByZero
// hold the last result until the next accepted start completes.
module sequential_divider
  import sequential_divider_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iDividend,
  input  logic [WIDTH-1:0] iDivisor,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oQuotient,
  output logic [WIDTH-1:0] oRemainder,
  output logic             oDivByZero
);
  localparam int CW = $clog2(WIDTH);
  divState_t state, nextState;
  logic [WIDTH-1:0] shiftReg, divisorReg, partRem, nextRem, nextShift;
  logic [CW-1:0] count;
  logic [WIDTH:0] trial;
  logic accept, noBorrow;
  assign accept = iStart && (state != DIV_RUN);
  // shiftReg shifts the dividend out of its MSB while quotient bits enter at its LSB,
  // so after WIDTH steps it holds the complete quotient.
  always_comb begin
    trial     = {partRem, shiftReg[WIDTH-1]} - {1'b0, divisorReg};
    noBorrow  = !trial[WIDTH];
    nextRem   = noBorrow ? trial[WIDTH-1:0] : {partRem[WIDTH-2:0], shiftReg[WIDTH-1]};
    nextShift = {shiftReg[WIDTH-2:0], noBorrow};
  end
  always_comb begin
    nextState = accept ? ((iDivisor == '0) ? DIV_DONE : DIV_RUN)
              : (state == DIV_RUN) ? ((count == '0) ? DIV_DONE : DIV_RUN)
              : DIV_IDLE;
  end
  always_comb begin
    oBusy = (state == DIV_RUN);
    oDone = (state == DIV_DONE);
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= DIV_IDLE;
      shiftReg   <= '0;
      divisorReg <= '0;
      partRem    <= '0;
      count      <= '0;
      oQuotient  <= '0;
      oRemainder <= '0;
      oDivByZero <= 1'b0;
    end else begin
      state <= nextState;
      if (accept) begin
        if (iDivisor == '0) begin
          oQuotient  <= '1;
          oRemainder <= iDividend;
          oDivByZero <= 1'b1;
        end else begin
          shiftReg   <= iDividend;
          divisorReg <= iDivisor;
          partRem    <= '0;
          count      <= CW'(WIDTH - 1);
        end
      end else if (state == DIV_RUN) begin
        shiftReg <= nextShift;
        partRem  <= nextRem;
        count    <= count - 1'b1;
        if (count == '0) begin
          oQuotient  <= nextShift;
          oRemainder <= nextRem;
          oDivByZero <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_sequential_divider.sv
// tb_sequential_divider: directed table, corner sequences and random model check of sequential_divider
module tb_sequential_divider;
  logic Clock = 1'b0, Reset = 1'b1, iStart = 1'b0;
  logic [15:0] iDividend = '0, iDivisor = '0;
  logic oBusy, oDone, oDivByZero;
  logic [15:0] oQuotient, oRemainder;
  int tests = 0, fails = 0;

  typedef struct {
    logic [15:0] a, b, q, r;
  } vec_t;
  vec_t vecs[$];

  sequential_divider #(.WIDTH(16)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iDividend(iDividend), .iDivisor(iDivisor),
    .oBusy(oBusy), .oDone(oDone), .oQuotient(oQuotient), .oRemainder(oRemainder),
    .oDivByZero(oDivByZero)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Drive a request so it is sampled on the next rising edge, then drop iStart
  // and scramble the operands to prove they are not resampled.
  task automatic pulseStart(input logic [15:0] a, input logic [15:0] b);
    @(negedge Clock);
    iStart = 1'b1; iDividend = a; iDivisor = b;
    @(posedge Clock);
    #1 iStart = 1'b0; iDividend = 16'($urandom); iDivisor = 16'($urandom);
  endtask

  // Counts cycles after the accepting edge until oDone; notes any cycle before it without oBusy.
  task automatic waitDone(output int n, output bit busyGap);
    n = 0; busyGap = 0;
    do begin
      @(negedge Clock);
      n++;
      if (!oDone && !oBusy) busyGap = 1;
    end while (!oDone && n < 40);
  endtask

  task automatic runDiv(input logic [15:0] a, input logic [15:0] b, input logic [15:0] eq,
                        input logic [15:0] er, input string nm);
    int n; bit gap;
    pulseStart(a, b);
    waitDone(n, gap);
    check({nm, " latency"}, n, (b == 0) ? 1 : 17);
    check({nm, " busy gap"}, gap, 0);
    check({nm, " busy at done"}, oBusy, 0);
    check({nm, " quotient"}, oQuotient, eq);
    check({nm, " remainder"}, oRemainder, er);
    check({nm, " divbyzero"}, oDivByZero, b == 0);
  endtask

  initial begin
    int n; bit gap; int doneSeen; bit busyBad;
    logic [15:0] a, b;
    vecs.push_back('{16'd100, 16'd7, 16'd14, 16'd2});
    vecs.push_back('{16'hFFFF, 16'd1, 16'hFFFF, 16'd0});
    vecs.push_back('{16'd5, 16'd0, 16'hFFFF, 16'd5});
    vecs.push_back('{16'd1000, 16'd33, 16'd30, 16'd10});
    vecs.push_back('{16'd500, 16'd3, 16'd166, 16'd2});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 16'd1, 16'd0});
    vecs.push_back('{16'd1234, 16'd1235, 16'd0, 16'd1234});
    vecs.push_back('{16'd0, 16'd5, 16'd0, 16'd0});
    vecs.push_back('{16'd0, 16'd0, 16'hFFFF, 16'd0});
    vecs.push_back('{16'h8000, 16'd2, 16'h4000, 16'd0});
    vecs.push_back('{16'hFFFF, 16'h0100, 16'h00FF, 16'h00FF});
    vecs.push_back('{16'd65535, 16'd7, 16'd9362, 16'd1});

    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    check("reset busy", oBusy, 0);
    check("reset done", oDone, 0);
    check("reset quotient", oQuotient, 0);
    check("reset remainder", oRemainder, 0);
    check("reset divbyzero", oDivByZero, 0);

    foreach (vecs[i])
      runDiv(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, $sformatf("vec%0d", i));

    // Back-to-back: second start accepted in the DONE cycle, no IDLE gap.
    pulseStart(16'hFFFF, 16'd1);
    waitDone(n, gap);
    check("b2b first latency", n, 17);
    check("b2b first quotient", oQuotient, 16'hFFFF);
    check("b2b first remainder", oRemainder, 0);
    iStart = 1'b1; iDividend = 16'd3; iDivisor = 16'd10;
    @(posedge Clock);
    #1 iStart = 1'b0; iDividend = 16'($urandom); iDivisor = 16'($urandom);
    @(negedge Clock);
    check("b2b no idle gap", oBusy, 1);
    waitDone(n, gap);
    check("b2b second latency", n + 1, 17);
    check("b2b second quotient", oQuotient, 0);
    check("b2b second remainder", oRemainder, 3);

    // Restarts while running are ignored.
    @(negedge Clock);
    pulseStart(16'd1000, 16'd33);
    doneSeen = 0; busyBad = 0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge Clock);
      if (c < 17 && oDone) doneSeen++;
      if (c <= 16 && !oBusy) busyBad = 1;
      if (c == 17) begin
        check("repulse done", oDone, 1);
        check("repulse quotient", oQuotient, 16'd30);
        check("repulse remainder", oRemainder, 16'd10);
      end
      if (c == 18) begin
        check("repulse idle done", oDone, 0);
        check("repulse idle busy", oBusy, 0);
      end
      iStart = (c == 5 || c == 10); iDividend = 16'd9; iDivisor = 16'd3;
    end
    iStart = 1'b0;
    check("repulse early done", doneSeen, 0);
    check("repulse busy", busyBad, 0);

    // Reset mid-operation aborts without oDone.
    pulseStart(16'd500, 16'd3);
    for (int c = 1; c <= 8; c++) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("abort busy", oBusy, 0);
    check("abort done", oDone, 0);
    check("abort quotient", oQuotient, 0);
    check("abort remainder", oRemainder, 0);
    check("abort divbyzero", oDivByZero, 0);
    doneSeen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clock);
      if (oDone || oBusy) doneSeen++;
    end
    check("abort stays idle", doneSeen, 0);
    runDiv(16'd500, 16'd3, 16'd166, 16'd2, "after abort");

    // Random pairs against plain-arithmetic model plus the division identity.
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      case (i % 5)
        0: b = 16'($urandom_range(0, 15));
        1: b = a + 16'd1;
        2: b = a;
        default: b = 16'($urandom);
      endcase
      if (i == 0) begin a = 16'hFFFF; b = 16'hFFFF; end
      runDiv(a, b, (b == 0) ? 16'hFFFF : a / b, (b == 0) ? a : a % b, $sformatf("rnd%0d", i));
      if (b != 0)
        check($sformatf("rnd%0d identity", i),
              (32'(oQuotient) * 32'(b) + 32'(oRemainder) == 32'(a)) && (oRemainder < b), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
